// File: rtl/tick_wave_gen_pkg.sv
// Shared encodings for the tick-driven waveform generator:
// waveform select codes and triangle direction states.
package tick_wave_pkg;

   typedef enum logic [1:0] {
      WSEL_SAW  = 2'd0,
      WSEL_TRI  = 2'd1,
      WSEL_SQR  = 2'd2,
      WSEL_RSAW = 2'd3
   } wsel_e;

   typedef enum logic {
      TRI_UP   = 1'b0,
      TRI_DOWN = 1'b1
   } tri_state_e;

endpackage

// File: rtl/tick_wave_gen_if.sv
// Control and sample bus of the waveform generator. The master side drives
// the step strobe and mode controls; the slave side returns the samples.
interface tick_wave_gen_if #(
   parameter int W = 8
);
   logic         tick;
   logic         en;
   logic [1:0]   wsel;
   logic [W-1:0] duty;
   logic [W-1:0] sample;
   logic         valid;
   logic         period_done;

   modport master (
      output tick, en, wsel, duty,
      input  sample, valid, period_done
   );

   modport slave (
      input  tick, en, wsel, duty,
      output sample, valid, period_done
   );
endinterface

// File: rtl/tick_wave_gen_phase_cnt.sv
// W-bit up/down counter with step enable and synchronous clear; tc flags
// that the value produced by this cycle equals the supplied terminal value.
module wave_phase_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic         up,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt_next,
   output logic         tc
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] base;

   // A clear on a step cycle restarts from zero and still takes that step.
   always_comb begin
      base  = clr ? '0 : cnt_q;
      cnt_d = base;
      if (en) begin
         cnt_d = up ? (base + W'(1)) : (base - W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_next = cnt_d;
   assign tc       = (cnt_d == term);

endmodule

// File: rtl/tick_wave_gen.sv
// Tick-stepped waveform generator: saw, triangle, square and reverse saw
// from a free-running phase counter and a bouncing triangle level.
module tick_wave_gen #(
   parameter int W = 8
) (
   input  logic            clk,
   input  logic            rst,
   tick_wave_gen_if.slave  bus
);
   import tick_wave_pkg::*;

   logic         step;
   logic         resync;
   wsel_e        wsel_in;
   wsel_e        wsel_q, wsel_d;
   tri_state_e   state_q, state_d;
   tri_state_e   tri_dir;
   logic [W-1:0] phase_nxt;
   logic         phase_tc;
   logic [W-1:0] tri_nxt;
   logic [W-1:0] tri_term;
   logic         tri_tc;
   logic [W-1:0] sample_q, sample_d;
   logic         valid_q, valid_d;
   logic         period_done_q, period_done_d;

   assign wsel_in = wsel_e'(bus.wsel);
   assign step    = bus.en & bus.tick;
   assign resync  = step && (wsel_in != wsel_q);

   // A mode change restarts the triangle climbing from zero on the same step.
   assign tri_dir  = resync ? TRI_UP : state_q;
   assign tri_term = (tri_dir == TRI_UP) ? '1 : '0;

   wave_phase_cnt #(.W(W)) u_phase (
      .clk      (clk),
      .rst      (rst),
      .en       (step),
      .clr      (resync),
      .up       (1'b1),
      .term     ('0),
      .cnt_next (phase_nxt),
      .tc       (phase_tc)
   );

   wave_phase_cnt #(.W(W)) u_tri (
      .clk      (clk),
      .rst      (rst),
      .en       (step),
      .clr      (resync),
      .up       (tri_dir == TRI_UP),
      .term     (tri_term),
      .cnt_next (tri_nxt),
      .tc       (tri_tc)
   );

   always_comb begin
      state_d       = state_q;
      wsel_d        = wsel_q;
      sample_d      = sample_q;
      valid_d       = 1'b0;
      period_done_d = 1'b0;
      if (step) begin
         state_d = tri_dir;
         if (tri_tc) begin
            state_d = (tri_dir == TRI_UP) ? TRI_DOWN : TRI_UP;
         end
         wsel_d  = wsel_in;
         valid_d = 1'b1;
         case (wsel_in)
            WSEL_SAW: begin
               sample_d      = phase_nxt;
               period_done_d = phase_tc;
            end
            WSEL_TRI: begin
               sample_d      = tri_nxt;
               period_done_d = tri_tc && (tri_dir == TRI_DOWN);
            end
            WSEL_SQR: begin
               sample_d      = (phase_nxt < bus.duty) ? '1 : '0;
               period_done_d = phase_tc;
            end
            WSEL_RSAW: begin
               sample_d      = ~phase_nxt;
               period_done_d = phase_tc;
            end
            default: begin
               sample_d = sample_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= TRI_UP;
         wsel_q        <= WSEL_SAW;
         sample_q      <= '0;
         valid_q       <= 1'b0;
         period_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wsel_q        <= wsel_d;
         sample_q      <= sample_d;
         valid_q       <= valid_d;
         period_done_q <= period_done_d;
      end
   end

   assign bus.sample      = sample_q;
   assign bus.valid       = valid_q;
   assign bus.period_done = period_done_q;

endmodule

// File: tb/tb_tick_wave_gen.sv
// Directed bench for tick_wave_gen (W=8): each waveform, mode change while
// idle, asynchronous reset mid-triangle and an enable freeze.
module tb_tick_wave_gen;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   hits;
   int   ph;

   tick_wave_gen_if #(.W(W)) bus ();

   tick_wave_gen #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic t);
      bus.tick = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst      = 1'b1;
      bus.tick = 1'b0;
      bus.en   = 1'b0;
      bus.wsel = 2'd0;
      bus.duty = 8'd0;
      #1;
      check("rst_sample", 32'(bus.sample), 0);
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_pd", 32'(bus.period_done), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      $display("tx reset: sample=%0d valid=%0d", bus.sample, bus.valid);

      // Saw, one tick every fourth cycle
      bus.en   = 1'b1;
      bus.wsel = 2'd0;
      for (int k = 0; k < 256; k++) begin
         for (int j = 0; j < 3; j++) begin
            cyc(1'b0);
            check("saw_idle_valid", 32'(bus.valid), 0);
            check("saw_idle_pd", 32'(bus.period_done), 0);
         end
         cyc(1'b1);
         check("saw_valid", 32'(bus.valid), 1);
         check("saw_sample", 32'(bus.sample), (k + 1) % 256);
         check("saw_pd", 32'(bus.period_done), (k == 255) ? 1 : 0);
      end
      $display("tx saw: last sample=%0d", bus.sample);

      // Triangle, tick every cycle; the mode change restarts it at 1
      bus.wsel = 2'd1;
      hits = 0;
      for (int k = 1; k <= 510; k++) begin
         cyc(1'b1);
         check("tri_sample", 32'(bus.sample), (k <= 255) ? k : 510 - k);
         check("tri_pd", 32'(bus.period_done), (k == 510) ? 1 : 0);
         if (bus.sample == 8'd255) hits++;
      end
      check("tri_peak_once", hits, 1);
      $display("tx triangle: peaks=%0d", hits);

      // Square with duty 64, then 0, then 255
      bus.wsel = 2'd2;
      bus.duty = 8'd64;
      ph = 0;
      hits = 0;
      for (int k = 0; k < 256; k++) begin
         cyc(1'b1);
         ph = (ph + 1) % 256;
         check("sq64_sample", 32'(bus.sample), (ph < 64) ? 255 : 0);
         check("sq64_pd", 32'(bus.period_done), (ph == 0) ? 1 : 0);
         if (bus.sample == 8'd255) hits++;
      end
      check("sq64_high_count", hits, 64);
      $display("tx square duty=64: highs=%0d", hits);

      bus.duty = 8'd0;
      hits = 0;
      for (int k = 0; k < 256; k++) begin
         cyc(1'b1);
         ph = (ph + 1) % 256;
         check("sq0_sample", 32'(bus.sample), 0);
         if (bus.sample != 8'd0) hits++;
      end
      check("sq0_high_count", hits, 0);
      $display("tx square duty=0: highs=%0d", hits);

      bus.duty = 8'd255;
      hits = 0;
      for (int k = 0; k < 256; k++) begin
         cyc(1'b1);
         ph = (ph + 1) % 256;
         check("sq255_sample", 32'(bus.sample), (ph < 255) ? 255 : 0);
         if (bus.sample == 8'd255) hits++;
      end
      check("sq255_high_count", hits, 255);
      $display("tx square duty=255: highs=%0d", hits);

      // Mode change to reverse saw while disabled takes effect on the next step
      bus.wsel = 2'd0;
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1);
         check("pre_rsaw_sample", 32'(bus.sample), k);
      end
      bus.en   = 1'b0;
      bus.wsel = 2'd3;
      for (int k = 0; k < 5; k++) begin
         cyc(1'b0);
         check("rsaw_hold_sample", 32'(bus.sample), 5);
         check("rsaw_hold_valid", 32'(bus.valid), 0);
      end
      bus.en = 1'b1;
      cyc(1'b0);
      check("rsaw_idle_sample", 32'(bus.sample), 5);
      cyc(1'b1);
      check("rsaw_first_sample", 32'(bus.sample), 254);
      check("rsaw_first_valid", 32'(bus.valid), 1);
      check("rsaw_first_pd", 32'(bus.period_done), 0);
      cyc(1'b1);
      check("rsaw_second_sample", 32'(bus.sample), 253);
      $display("tx reverse saw: sample=%0d", bus.sample);

      // Asynchronous reset in the falling half of the triangle
      bus.wsel = 2'd1;
      for (int k = 1; k <= 410; k++) begin
         cyc(1'b1);
      end
      check("tri_at_100", 32'(bus.sample), 100);
      bus.tick = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("arst_sample", 32'(bus.sample), 0);
      check("arst_valid", 32'(bus.valid), 0);
      check("arst_pd", 32'(bus.period_done), 0);
      @(posedge clk);
      #1;
      check("arst_hold_pd", 32'(bus.period_done), 0);
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cyc(1'b1);
         check("post_rst_sample", 32'(bus.sample), k);
         check("post_rst_pd", 32'(bus.period_done), 0);
      end
      $display("tx async reset: sample=%0d", bus.sample);

      // Enable low for 20 cycles with tick toggling
      bus.wsel = 2'd0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1'b1);
      end
      check("pre_freeze_sample", 32'(bus.sample), 10);
      bus.en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc(k[0]);
         check("freeze_sample", 32'(bus.sample), 10);
         check("freeze_valid", 32'(bus.valid), 0);
         check("freeze_pd", 32'(bus.period_done), 0);
      end
      bus.en = 1'b1;
      cyc(1'b1);
      check("resume_sample", 32'(bus.sample), 11);
      check("resume_valid", 32'(bus.valid), 1);
      cyc(1'b1);
      check("resume_next_sample", 32'(bus.sample), 12);
      $display("tx freeze/resume: sample=%0d", bus.sample);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tick_wave_gen.md
TICK_WAVE_GEN -- requirements
Module: tick_wave_gen

Interface
REQ-001 SHALL have parameter W, default 8, meaning sample and phase width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port tick  input  1  step strobe from the upstream frequency divider carry-out; one step per high cycle.
REQ-005 SHALL have port en  input  1  run enable; low freezes all state.
REQ-006 SHALL have port wsel  input  2  waveform select: 0 saw, 1 triangle, 2 square, 3 reverse saw.
REQ-007 SHALL have port duty  input  W  square-wave high threshold.
REQ-008 SHALL have port sample  output  W  registered waveform sample.
REQ-009 SHALL have port valid  output  1  one-cycle pulse marking a new sample.
REQ-010 SHALL have port period_done  output  1  one-cycle pulse when a waveform period completes.

Function
REQ-011 SHALL define a step as a cycle with en=1 and tick=1; all other cycles SHALL leave every register unchanged, except valid and period_done, which SHALL be 0.
REQ-012 SHALL keep phase, a W-bit counter, incremented by 1 per step and wrapping 2^W-1 -> 0.
REQ-013 SHALL update sample, valid and period_done on the clock edge ending the step cycle, giving one-cycle latency from tick.
REQ-014 SHALL, for saw (0), set sample = phase value after the increment.
REQ-015 SHALL, for reverse saw (3), set sample = 2^W-1 minus the new phase.
REQ-016 SHALL, for square (2), set sample = all-ones when the new phase < duty, else 0.
REQ-017 SHALL treat duty=0 as constant 0 and duty=2^W-1 as high for all phases except 2^W-1.
REQ-018 SHALL, for triangle (1), run FSM states UP and DOWN with its own W-bit level tri.
REQ-019 SHALL, in UP, increment tri per step and move to DOWN on the step that makes tri = 2^W-1.
REQ-020 SHALL, in DOWN, decrement tri per step and move to UP on the step that makes tri = 0.
REQ-021 SHALL make the triangle period 2*(2^W-1) steps (510 for W=8), with each peak emitted exactly once.
REQ-022 SHALL set sample = tri for triangle.
REQ-023 SHALL pulse period_done on the step where phase wraps to 0 for modes 0, 2 and 3.
REQ-024 SHALL pulse period_done on the step where the triangle returns to 0 for mode 1.
REQ-025 SHALL keep a registered copy wsel_q and compare it with wsel on each step.
REQ-026 SHALL, when wsel differs from wsel_q on a step, resynchronise: phase, tri and the FSM restart from 0/UP, wsel_q takes the new value, and that step emits the first sample of the new waveform (value 1 for saw).
REQ-027 SHALL ignore wsel changes on non-step cycles until the next step.
REQ-028 SHALL sample duty only on step cycles; duty changes take effect on the next step.
REQ-029 SHALL hold sample during en=0; on re-enable, stepping resumes from the held state.

Reset
REQ-030 SHALL, on rst, clear sample, valid, period_done, phase and tri to 0, set the FSM to UP and wsel_q to 0, irrespective of clk.
REQ-031 SHALL make reset asserted mid-period abort the waveform with no period_done pulse; the first step after release emits sample 1 for saw.

Structure
REQ-032 SHALL place the wsel encodings and the triangle state encoding (UP/DOWN) in the shared package tick_wave_pkg.
REQ-033 SHALL implement phase and tri stepping in one sub-module, wave_phase_cnt: a W-bit up/down counter with enable, synchronous clear, and terminal-count flag.
REQ-034 SHALL contain all output registers in the top level, each with a single driver.

Verification
REQ-035 SHALL test: W=8, wsel=0, tick every 4th cycle, 256 steps -> sample 1..255,0; period_done once at sample 0; valid exactly every 4th cycle.
REQ-036 SHALL test: wsel=1, tick every cycle -> sample rises 1..255, falls 254..0; period_done at step 510; 255 emitted once.
REQ-037 SHALL test: wsel=2, duty=64, 256 steps -> exactly 64 samples =255, samples at phases 64..255 =0; duty=0 gives all 0.
REQ-038 SHALL test: wsel 0->3 while en=0 and tick idle -> no change until the next step, which emits 254 and restarts the phase.
REQ-039 SHALL test: rst pulsed asynchronously mid-triangle (tri=100, DOWN) -> immediate sample=0 and FSM=UP, no period_done; next step emits 1.
REQ-040 SHALL test: en=0 for 20 cycles with tick toggling -> sample, valid=0 and phase unchanged; resume continues at the next value.
